// File: rtl/nand_vector_sequencer_pkg.sv
// rtl/nand_vector_sequencer_pkg.sv - shared types, widths and the ideal NAND reference for the vector sequencer
package nand_seq_pkg;

    localparam int N_MAX = 4;
    localparam int ERR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    // Inputs at or above n_in are tied high on the gate, so they are forced to 1 here too.
    function automatic logic nand_exp(input logic [N_MAX-1:0] vec, input int n_in);
        logic [N_MAX-1:0] v;
        v = vec;
        for (int i = 0; i < N_MAX; i++) begin
            if (i >= n_in) v[i] = 1'b1;
        end
        return ~&v;
    endfunction

endpackage

// File: rtl/nand_vector_sequencer_settle_timer.sv
// rtl/nand_vector_sequencer_settle_timer.sv - loadable down-counter that flags expiry at zero
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/nand_vector_sequencer.sv
// rtl/nand_vector_sequencer.sv - exhaustive stimulus and check sequencer for 2..4 input NAND cells
module nand_vector_sequencer
    import nand_seq_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic [N_MAX-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_vld,
    output logic [N_MAX-1:0] fail_vec
);

    localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYC - 1);
    localparam logic [N_MAX-1:0] VEC_LAST    = N_MAX'((1 << N_IN) - 1);
    localparam logic [N_MAX-1:0] HI_MASK     = ~VEC_LAST;

    seq_state_t       state_q, state_d;
    logic [N_MAX-1:0] vec_q;
    logic [N_MAX-1:0] dut_in_q;
    logic [ERR_W-1:0] err_q;
    logic             fail_vld_q;
    logic [N_MAX-1:0] fail_vec_q;

    logic timer_load;
    logic timer_expire;
    logic run_start;
    logic advance;
    logic check;
    logic mismatch;

    settle_timer #(
        .W (TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        run_start  = 1'b0;
        advance    = 1'b0;
        check      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                    run_start  = 1'b1;
                end
            end
            SETTLE: begin
                if (timer_expire) state_d = CHECK;
            end
            CHECK: begin
                check = 1'b1;
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                    advance    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Case inequality so an undriven or unknown gate output is scored as a failure.
    assign mismatch = check && (dut_out !== nand_exp(vec_q, N_IN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            dut_in_q   <= '1;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                vec_q      <= '0;
                dut_in_q   <= HI_MASK;
                err_q      <= '0;
                fail_vld_q <= 1'b0;
            end
            if (mismatch) begin
                err_q <= err_q + ERR_W'(1);
                if (!fail_vld_q) begin
                    fail_vec_q <= dut_in_q;
                    fail_vld_q <= 1'b1;
                end
            end
            if (advance) begin
                vec_q    <= vec_q + N_MAX'(1);
                dut_in_q <= HI_MASK | (vec_q + N_MAX'(1));
            end
        end
    end

    assign dut_in   = dut_in_q;
    assign busy     = (state_q == SETTLE) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass     = done && (err_q == '0);
    assign err_cnt  = err_q;
    assign fail_vld = fail_vld_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_nand_vector_sequencer.sv
// tb/tb_nand_vector_sequencer.sv - randomized self-checking bench for nand_vector_sequencer
`timescale 1ns/1ps
module tb_nand_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic [3:0] dut_in_w   [3];
    logic       dut_out_w  [3];
    logic       busy_w     [3];
    logic       done_w     [3];
    logic       pass_w     [3];
    logic [4:0] err_w      [3];
    logic       fail_vld_w [3];
    logic [3:0] fail_vec_w [3];

    // Gate fault modes: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 inverted, 4 random per-vector flips.
    int          fault_mode [3] = '{0, 0, 0};
    logic [15:0] fault_mask [3] = '{16'h0, 16'h0, 16'h0};

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    function automatic int s_of(input int g);
        return (g == 1) ? 1 : 2;
    endfunction

    function automatic logic gate_fn(input int mode, input logic [15:0] mask, input logic [3:0] a);
        case (mode)
            0:       return ~&a;
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return &a;
            default: return (~&a) ^ mask[a];
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign dut_out_w[g] = gate_fn(fault_mode[g], fault_mask[g], dut_in_w[g]);
        nand_vector_sequencer #(
            .N_IN       (g + 2),
            .SETTLE_CYC ((g == 1) ? 1 : 2)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .dut_out  (dut_out_w[g]),
            .dut_in   (dut_in_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .pass     (pass_w[g]),
            .err_cnt  (err_w[g]),
            .fail_vld (fail_vld_w[g]),
            .fail_vec (fail_vec_w[g])
        );
    end

    task automatic chk(input string name, input int g, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %0h, expected %0h", name, g, act, exp);
        end
    endtask

    // Reference model: edges since the accepted start, plus which vectors the faulty gate will fail.
    int k_m   [3] = '{0, 0, 0};
    bit act_m [3] = '{0, 0, 0};
    bit fail_m [3][16];

    always begin : model_and_compare
        int n, s, nv, tot, kk, vi, nerr, first;
        logic [3:0] hi;
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            n = g + 2; s = s_of(g); nv = 1 << n; tot = nv * (s + 1);
            hi = 4'(15 << n);
            if (!rst_n) begin
                act_m[g] = 1'b0; k_m[g] = 0;
            end else if (start && (!act_m[g] || k_m[g] >= tot)) begin
                act_m[g] = 1'b1; k_m[g] = 0;
                for (int j = 0; j < 16; j++) begin
                    fail_m[g][j] = (j < nv) &&
                        (gate_fn(fault_mode[g], fault_mask[g], hi | 4'(j)) != (j != nv - 1));
                end
            end else if (act_m[g] && k_m[g] < tot) begin
                k_m[g] = k_m[g] + 1;
            end
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n = g + 2; s = s_of(g); nv = 1 << n; tot = nv * (s + 1);
            hi = 4'(15 << n);
            if (!act_m[g]) begin
                chk("idle_dut_in", g, dut_in_w[g], 4'hF);
                chk("idle_busy", g, busy_w[g], 0);
                chk("idle_done", g, done_w[g], 0);
                chk("idle_pass", g, pass_w[g], 0);
                chk("idle_err", g, err_w[g], 0);
                chk("idle_fail_vld", g, fail_vld_w[g], 0);
                chk("idle_fail_vec", g, fail_vec_w[g], 0);
            end else begin
                kk = k_m[g];
                vi = (kk >= tot) ? nv - 1 : kk / (s + 1);
                nerr = 0; first = -1;
                for (int j = 0; j < nv; j++) begin
                    if (fail_m[g][j] && (j + 1) * (s + 1) <= kk) begin
                        nerr++;
                        if (first < 0) first = j;
                    end
                end
                chk("dut_in", g, dut_in_w[g], hi | 4'(vi));
                chk("busy", g, busy_w[g], kk < tot);
                chk("done", g, done_w[g], kk >= tot);
                chk("pass", g, pass_w[g], (kk >= tot) && (nerr == 0));
                chk("err_cnt", g, err_w[g], nerr);
                chk("fail_vld", g, fail_vld_w[g], nerr > 0);
                if (nerr > 0) chk("fail_vec", g, fail_vec_w[g], hi | 4'(first));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_all_done();
        int n;
        n = 0;
        while (!(done_w[0] && done_w[1] && done_w[2]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_bound", 0, n < 100, 1);
    endtask

    task automatic randomize_faults();
        for (int g = 0; g < 3; g++) begin
            fault_mode[g] = $urandom_range(0, 4);
            fault_mask[g] = 16'($urandom);
        end
    endtask

    initial begin
        int done_at [3];
        repeat (3) @(negedge clk);
        chk("lit_rst_dut_in", 2, dut_in_w[2], 4'b1111);
        chk("lit_rst_busy", 2, busy_w[2], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1: ideal 2-in, stuck-at-1 3-in, ideal 4-in, with a stray start mid-run.
        fault_mode = '{0, 1, 0};
        pulse_start();
        chk("lit_n2_vec0", 0, dut_in_w[0], 4'b1100);
        done_at = '{0, 0, 0};
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            if (cyc == 2) start = 1'b1;
            if (cyc == 3) start = 1'b0;
            if (cyc == 3) chk("lit_n2_vec1", 0, dut_in_w[0], 4'b1101);
            if (cyc == 6) chk("lit_n2_vec2", 0, dut_in_w[0], 4'b1110);
            if (cyc == 9) chk("lit_n2_vec3", 0, dut_in_w[0], 4'b1111);
            for (int g = 0; g < 3; g++) begin
                if (done_w[g] && done_at[g] == 0) done_at[g] = cyc;
            end
        end
        chk("lit_latency_n2", 0, done_at[0], 12);
        chk("lit_latency_n3", 1, done_at[1], 16);
        chk("lit_latency_n4", 2, done_at[2], 48);
        chk("lit_n2_pass", 0, pass_w[0], 1);
        chk("lit_n2_fail_vld", 0, fail_vld_w[0], 0);
        chk("lit_n3_err", 1, err_w[1], 1);
        chk("lit_n3_fail_vec", 1, fail_vec_w[1], 4'b1111);
        chk("lit_n3_pass", 1, pass_w[1], 0);
        chk("lit_n4_pass", 2, pass_w[2], 1);

        // Run 2: restart from DONE; 4-in gate fails every vector.
        fault_mode = '{4, 4, 3};
        fault_mask[0] = 16'($urandom);
        fault_mask[1] = 16'($urandom);
        pulse_start();
        chk("lit_restart_err", 1, err_w[1], 0);
        chk("lit_restart_fail_vld", 1, fail_vld_w[1], 0);
        wait_all_done();
        chk("lit_n4_all_fail_err", 2, err_w[2], 16);
        chk("lit_n4_all_fail_vec", 2, fail_vec_w[2], 4'b0000);

        // Run 3: reset while the 4-in run is at vector 5.
        fault_mode = '{0, 2, 3};
        pulse_start();
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (cyc == 15) begin
                chk("lit_mid_vec5", 2, dut_in_w[2], 4'b0101);
                chk("lit_mid_err5", 2, err_w[2], 5);
                rst_n = 1'b0;
            end
            if (cyc == 16) begin
                chk("lit_post_rst_dut_in", 2, dut_in_w[2], 4'b1111);
                chk("lit_post_rst_busy", 2, busy_w[2], 0);
                chk("lit_post_rst_err", 2, err_w[2], 0);
                rst_n = 1'b1;
            end
        end
        fault_mode = '{0, 0, 0};
        pulse_start();
        wait_all_done();
        chk("lit_fresh_pass", 2, pass_w[2], 1);

        // Randomized runs, some cut short by a reset at a random point.
        for (int r = 0; r < 8; r++) begin
            randomize_faults();
            pulse_start();
            if (r % 2 == 1) begin
                repeat ($urandom_range(1, 45)) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                randomize_faults();
                pulse_start();
            end
            wait_all_done();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
